// File: rtl/inv_cipher_seq.sv
// inv_cipher_seq: iterative AES inverse cipher, one decryption round per clock.
//
// Ports:
//   clk         rising-edge clock
//   reset       synchronous active-high reset
//   start       decrypt request, accepted only when idle and key_valid is high
//   key_valid   expanded key schedule on w is valid
//   ciphertext  input block, sampled on the accept edge only
//   w           expanded schedule, round key r = w[r*128 +: 128]; stable while busy
//   busy        operation in flight (cycle after accept through the final round)
//   done        one-cycle pulse, plaintext valid
//   plaintext   last result, held until the next done
//   round_idx   round key index in use (Nr when idle, 0 in the final round)
module inv_cipher_seq #(
    parameter int unsigned Nr = 10,
    parameter int unsigned Nk = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  key_valid,
    input  logic [127:0]          ciphertext,
    input  logic [128*(Nr+1)-1:0] w,
    output logic                  busy,
    output logic                  done,
    output logic [127:0]          plaintext,
    output logic [3:0]            round_idx
);

    if (!((Nk == 4 && Nr == 10) || (Nk == 6 && Nr == 12) || (Nk == 8 && Nr == 14))) begin : g_bad_params
        $error("inv_cipher_seq: illegal (Nk, Nr) pair");
    end

    typedef enum logic [1:0] {StIdle, StRound, StFinal} state_e;

    // GF(2^8) arithmetic, AES polynomial x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (a^2 * a^4 * ... * a^128); maps 0 to 0.
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] r;
        sq = a;
        r  = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq = gmul(sq, sq);
            r  = gmul(r, sq);
        end
        return r;
    endfunction

    // Inverse S-box: undo the affine map, then invert in GF(2^8).
    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        logic [7:0] y;
        y = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
        return ginv(y);
    endfunction

    // Byte i of the state lives at [127-8*i -: 8]; byte index = 4*column + row.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+4-r)%4)+r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = inv_sbox(s[127-8*i -: 8]);
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 32] = {
                gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
                gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
                gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
                gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
        end
        return o;
    endfunction

    state_e       state_q, state_d;
    logic [127:0] st_q, st_d;
    logic [3:0]   rnd_q, rnd_d;
    logic [127:0] pt_q, pt_d;
    logic         done_q, done_d;

    // rnd_q doubles as the key index in every state: Nr in idle (initial
    // AddRoundKey), Nr-1..1 in the rounds, 0 in the final round.
    logic [127:0] round_keys [Nr+1];
    for (genvar r = 0; r <= Nr; r++) begin : g_rk
        assign round_keys[r] = w[r*128 +: 128];
    end

    logic [127:0] round_key;
    logic [127:0] sub_key;
    assign round_key = round_keys[rnd_q];
    assign sub_key   = inv_sub_bytes(inv_shift_rows(st_q)) ^ round_key;

    always_comb begin
        state_d = state_q;
        st_d    = st_q;
        rnd_d   = rnd_q;
        pt_d    = pt_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start && key_valid) begin
                    st_d    = ciphertext ^ round_key;
                    rnd_d   = 4'(Nr - 1);
                    state_d = StRound;
                end
            end
            StRound: begin
                st_d  = inv_mix_columns(sub_key);
                rnd_d = rnd_q - 4'd1;
                if (rnd_q == 4'd1) state_d = StFinal;
            end
            StFinal: begin
                st_d    = sub_key;
                pt_d    = sub_key;
                done_d  = 1'b1;
                rnd_d   = 4'(Nr);
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            st_q    <= '0;
            rnd_q   <= 4'(Nr);
            pt_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            st_q    <= st_d;
            rnd_q   <= rnd_d;
            pt_q    <= pt_d;
            done_q  <= done_d;
        end
    end

    assign busy      = (state_q != StIdle);
    assign done      = done_q;
    assign plaintext = pt_q;
    assign round_idx = rnd_q;

endmodule

// File: tb/tb_inv_cipher_seq.sv
// tb_inv_cipher_seq: directed bench for inv_cipher_seq with AES-128 and AES-256
// instances, using FIPS-197 and SP800-38A ECB known-answer vectors.
module tb_inv_cipher_seq;

    logic          clk;
    logic          reset;
    logic          key_valid;
    logic          start_a, start_b;
    logic [127:0]  ct_a, ct_b;
    logic [1407:0] w_a;
    logic [1919:0] w_b;
    logic          busy_a, busy_b, done_a, done_b;
    logic [127:0]  pt_a, pt_b;
    logic [3:0]    ridx_a, ridx_b;
    logic [1919:0] tmp;

    int n_cmp;
    int n_fail;

    inv_cipher_seq #(.Nr(10), .Nk(4)) dut_a (
        .clk        (clk),
        .reset      (reset),
        .start      (start_a),
        .key_valid  (key_valid),
        .ciphertext (ct_a),
        .w          (w_a),
        .busy       (busy_a),
        .done       (done_a),
        .plaintext  (pt_a),
        .round_idx  (ridx_a)
    );

    inv_cipher_seq #(.Nr(14), .Nk(8)) dut_b (
        .clk        (clk),
        .reset      (reset),
        .start      (start_b),
        .key_valid  (key_valid),
        .ciphertext (ct_b),
        .w          (w_b),
        .busy       (busy_b),
        .done       (done_b),
        .plaintext  (pt_b),
        .round_idx  (ridx_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Forward S-box and key expansion, used only to build w.
    function automatic logic [7:0] tb_xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] tb_gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = tb_xtime(aa);
        end
        return p;
    endfunction

    function automatic logic [7:0] tb_sbox(input logic [7:0] x);
        logic [7:0] inv;
        inv = 8'h01;
        for (int i = 0; i < 254; i++) inv = tb_gmul(inv, x);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] t);
        return {tb_sbox(t[31:24]), tb_sbox(t[23:16]), tb_sbox(t[15:8]), tb_sbox(t[7:0])};
    endfunction

    // Key is MSB-aligned in 256 bits; round key r lands at [r*128 +: 128].
    function automatic logic [1919:0] expand_key(input logic [255:0] key, input int nk);
        logic [31:0]   wd [60];
        logic [31:0]   t;
        logic [7:0]    rc;
        logic [1919:0] res;
        int            nr;
        nr  = nk + 6;
        rc  = 8'h01;
        res = '0;
        for (int i = 0; i < nk; i++) wd[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            t = wd[i-1];
            if (i % nk == 0) begin
                t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = tb_xtime(rc);
            end else if (nk > 6 && i % nk == 4) begin
                t = sub_word(t);
            end
            wd[i] = wd[i-nk] ^ t;
        end
        for (int r = 0; r <= nr; r++) res[r*128 +: 128] = {wd[4*r], wd[4*r+1], wd[4*r+2], wd[4*r+3]};
        return res;
    endfunction

    localparam logic [127:0] Key128   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [255:0] Key256   =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] KeySp    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] Ct128    = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] Ct256    = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] PtFips   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CtSp1    = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
    localparam logic [127:0] PtSp1    = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] CtSp2    = 128'hf5d3d58503b9699de785895a96fdbaaf;
    localparam logic [127:0] PtSp2    = 128'hae2d8a571e03ac9c9eb76fac45af8e51;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        for (int k = 0; k < 2; k++) begin
            n_cmp += 4;
            if (busy_a !== 1'b0 || busy_b !== 1'b0) begin
                n_fail++;
                $display("FAIL reset busy k=%0d: got %b/%b expected 0/0", k, busy_a, busy_b);
            end
            if (done_a !== 1'b0 || done_b !== 1'b0) begin
                n_fail++;
                $display("FAIL reset done k=%0d: got %b/%b expected 0/0", k, done_a, done_b);
            end
            if (pt_a !== 128'h0 || pt_b !== 128'h0) begin
                n_fail++;
                $display("FAIL reset plaintext k=%0d: got %h/%h expected 0", k, pt_a, pt_b);
            end
            if (ridx_a !== 4'd10 || ridx_b !== 4'd14) begin
                n_fail++;
                $display("FAIL reset round_idx k=%0d: got %0d/%0d expected 10/14", k, ridx_a, ridx_b);
            end
            reset = 1'b0;
            step();
        end
    endtask

    task automatic test_aes128();
        logic       exp_busy, exp_done;
        logic [3:0] exp_ridx;
        tmp   = expand_key({Key128, 128'h0}, 4);
        w_a   = tmp[1407:0];
        ct_a  = Ct128;
        start_a = 1'b1;
        n_cmp++;
        if (busy_a !== 1'b0) begin
            n_fail++;
            $display("FAIL aes128 busy cyc=0: got %b expected 0", busy_a);
        end
        for (int cyc = 1; cyc <= 11; cyc++) begin
            step();
            start_a  = 1'b0;
            exp_busy = (cyc <= 10);
            exp_done = (cyc == 11);
            exp_ridx = (cyc <= 9) ? 4'(10 - cyc) : ((cyc == 10) ? 4'd0 : 4'd10);
            n_cmp += 3;
            if (busy_a !== exp_busy) begin
                n_fail++;
                $display("FAIL aes128 busy cyc=%0d: got %b expected %b", cyc, busy_a, exp_busy);
            end
            if (done_a !== exp_done) begin
                n_fail++;
                $display("FAIL aes128 done cyc=%0d: got %b expected %b", cyc, done_a, exp_done);
            end
            if (ridx_a !== exp_ridx) begin
                n_fail++;
                $display("FAIL aes128 round_idx cyc=%0d: got %0d expected %0d", cyc, ridx_a, exp_ridx);
            end
        end
        n_cmp++;
        if (pt_a !== PtFips) begin
            n_fail++;
            $display("FAIL aes128 plaintext: got %h expected %h", pt_a, PtFips);
        end
    endtask

    task automatic test_aes256();
        logic       exp_busy, exp_done;
        logic [3:0] exp_ridx;
        w_b     = expand_key(Key256, 8);
        ct_b    = Ct256;
        start_b = 1'b1;
        for (int cyc = 1; cyc <= 15; cyc++) begin
            step();
            start_b  = 1'b0;
            exp_busy = (cyc <= 14);
            exp_done = (cyc == 15);
            exp_ridx = (cyc <= 13) ? 4'(14 - cyc) : ((cyc == 14) ? 4'd0 : 4'd14);
            n_cmp += 3;
            if (busy_b !== exp_busy) begin
                n_fail++;
                $display("FAIL aes256 busy cyc=%0d: got %b expected %b", cyc, busy_b, exp_busy);
            end
            if (done_b !== exp_done) begin
                n_fail++;
                $display("FAIL aes256 done cyc=%0d: got %b expected %b", cyc, done_b, exp_done);
            end
            if (ridx_b !== exp_ridx) begin
                n_fail++;
                $display("FAIL aes256 round_idx cyc=%0d: got %0d expected %0d", cyc, ridx_b, exp_ridx);
            end
        end
        n_cmp++;
        if (pt_b !== PtFips) begin
            n_fail++;
            $display("FAIL aes256 plaintext: got %h expected %h", pt_b, PtFips);
        end
    endtask

    task automatic test_ignored_start();
        ct_a    = Ct128;
        start_a = 1'b1;
        for (int cyc = 1; cyc <= 14; cyc++) begin
            step();
            start_a = (cyc == 3 || cyc == 7);
            ct_a    = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;
            n_cmp += 2;
            if (busy_a !== (cyc <= 10)) begin
                n_fail++;
                $display("FAIL busy_ignore busy cyc=%0d: got %b expected %b", cyc, busy_a, cyc <= 10);
            end
            if (done_a !== (cyc == 11)) begin
                n_fail++;
                $display("FAIL busy_ignore done cyc=%0d: got %b expected %b", cyc, done_a, cyc == 11);
            end
        end
        n_cmp++;
        if (pt_a !== PtFips) begin
            n_fail++;
            $display("FAIL busy_ignore plaintext: got %h expected %h", pt_a, PtFips);
        end
        // start without a valid key schedule
        key_valid = 1'b0;
        start_a   = 1'b1;
        ct_a      = Ct128;
        for (int cyc = 1; cyc <= 14; cyc++) begin
            step();
            n_cmp += 3;
            if (busy_a !== 1'b0) begin
                n_fail++;
                $display("FAIL nokey busy cyc=%0d: got %b expected 0", cyc, busy_a);
            end
            if (done_a !== 1'b0) begin
                n_fail++;
                $display("FAIL nokey done cyc=%0d: got %b expected 0", cyc, done_a);
            end
            if (ridx_a !== 4'd10) begin
                n_fail++;
                $display("FAIL nokey round_idx cyc=%0d: got %0d expected 10", cyc, ridx_a);
            end
        end
        start_a   = 1'b0;
        key_valid = 1'b1;
    endtask

    task automatic test_back_to_back();
        tmp     = expand_key({KeySp, 128'h0}, 4);
        w_a     = tmp[1407:0];
        ct_a    = CtSp1;
        start_a = 1'b1;
        for (int cyc = 1; cyc <= 23; cyc++) begin
            step();
            if (cyc == 11) ct_a = CtSp2;
            if (cyc == 21) start_a = 1'b0;
            n_cmp += 2;
            if (done_a !== (cyc == 11 || cyc == 22)) begin
                n_fail++;
                $display("FAIL b2b done cyc=%0d: got %b expected %b", cyc, done_a,
                         cyc == 11 || cyc == 22);
            end
            if (busy_a !== !(cyc == 11 || cyc >= 22)) begin
                n_fail++;
                $display("FAIL b2b busy cyc=%0d: got %b expected %b", cyc, busy_a,
                         !(cyc == 11 || cyc >= 22));
            end
            if (cyc >= 11 && cyc <= 21) begin
                n_cmp++;
                if (pt_a !== PtSp1) begin
                    n_fail++;
                    $display("FAIL b2b plaintext1 cyc=%0d: got %h expected %h", cyc, pt_a, PtSp1);
                end
            end
            if (cyc >= 22) begin
                n_cmp++;
                if (pt_a !== PtSp2) begin
                    n_fail++;
                    $display("FAIL b2b plaintext2 cyc=%0d: got %h expected %h", cyc, pt_a, PtSp2);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        tmp     = expand_key({Key128, 128'h0}, 4);
        w_a     = tmp[1407:0];
        ct_a    = Ct128;
        start_a = 1'b1;
        for (int cyc = 1; cyc <= 6; cyc++) begin
            step();
            start_a = 1'b0;
            if (cyc == 5) begin
                n_cmp++;
                if (busy_a !== 1'b1) begin
                    n_fail++;
                    $display("FAIL midreset busy_before: got %b expected 1", busy_a);
                end
                reset = 1'b1;
            end
        end
        reset = 1'b0;
        n_cmp += 4;
        if (busy_a !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset busy: got %b expected 0", busy_a);
        end
        if (done_a !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset done: got %b expected 0", done_a);
        end
        if (pt_a !== 128'h0) begin
            n_fail++;
            $display("FAIL midreset plaintext: got %h expected 0", pt_a);
        end
        if (ridx_a !== 4'd10) begin
            n_fail++;
            $display("FAIL midreset round_idx: got %0d expected 10", ridx_a);
        end
        start_a = 1'b1;
        for (int cyc = 1; cyc <= 11; cyc++) begin
            step();
            start_a = 1'b0;
            n_cmp++;
            if (done_a !== (cyc == 11)) begin
                n_fail++;
                $display("FAIL midreset rerun done cyc=%0d: got %b expected %b", cyc, done_a, cyc == 11);
            end
        end
        n_cmp++;
        if (pt_a !== PtFips) begin
            n_fail++;
            $display("FAIL midreset rerun plaintext: got %h expected %h", pt_a, PtFips);
        end
    endtask

    initial begin
        n_cmp     = 0;
        n_fail    = 0;
        reset     = 1'b1;
        key_valid = 1'b1;
        start_a   = 1'b0;
        start_b   = 1'b0;
        ct_a      = '0;
        ct_b      = '0;
        w_a       = '0;
        w_b       = '0;
        test_reset();
        test_aes128();
        test_aes256();
        test_ignored_start();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
